// File: rtl/di_term_pkg.sv
// di_term_pkg: shared state encoding, status codes and default read data for the DI terminal router.
package di_term_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_TIMEOUT, ST_PROTO} state_t;
  localparam logic [15:0] ERR_UNDEF   = 16'hFFFF;
  localparam logic [15:0] ERR_TIMEOUT = 16'hFFFE;
  localparam logic [15:0] ERR_PROTO   = 16'hFFFD;
  localparam logic [31:0] DEFAULT_DATA_RST = 32'hAAAAAAAA;
endpackage

// File: rtl/di_term_watchdog.sv
// di_term_watchdog: counts consecutive not-ready cycles and flags expiry on the TIMEOUT_CYCLES-th one.
module di_term_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic ifclk,
  input  logic resetb,
  input  logic inc,
  input  logic clr,
  output logic expire
);
  localparam int W = $clog2(TIMEOUT_CYCLES);
  logic [W-1:0] cnt;
  always_ff @(posedge ifclk or negedge resetb)
    if (!resetb) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc) cnt <= cnt + 1'b1;
  assign expire = inc && !clr && cnt == W'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/di_term_router.sv
// di_term_router: routes the DI register bus to one of NUM_TERMS terminals, with per-transaction
// terminal latching, watchdog timeout, protocol-error detection and statistics.
module di_term_router
  import di_term_pkg::*;
#(
  parameter int                      NUM_TERMS      = 4,
  parameter logic [NUM_TERMS*16-1:0] TERM_ADDRS     = {16'h0003, 16'h0002, 16'h0001, 16'h0000},
  parameter int                      TIMEOUT_CYCLES = 1024,
  parameter logic [31:0]             DEFAULT_DATA   = DEFAULT_DATA_RST
) (
  input  logic                      ifclk,
  input  logic                      resetb,
  input  logic [15:0]               di_term_addr,
  input  logic                      di_read_mode,
  input  logic                      di_write_mode,
  input  logic                      di_read,
  input  logic                      di_write,
  output logic                      di_read_rdy,
  output logic                      di_write_rdy,
  output logic [31:0]               di_reg_datao,
  output logic [15:0]               di_transfer_status,
  output logic [NUM_TERMS-1:0]      term_sel,
  input  logic [NUM_TERMS*32-1:0]   term_reg_datao,
  input  logic [NUM_TERMS-1:0]      term_read_rdy,
  input  logic [NUM_TERMS-1:0]      term_write_rdy,
  input  logic [NUM_TERMS*16-1:0]   term_transfer_status,
  output logic [15:0]               txn_count,
  output logic [7:0]                err_count,
  output logic                      timeout_flag
);
  localparam int IW = NUM_TERMS > 1 ? $clog2(NUM_TERMS) : 1;
  state_t state, state_nx;
  logic [IW-1:0] lat_idx, match_idx, sel_idx;
  logic lat_vld, lat_rd, match_vld, sel_vld, rdy_rel, wd_inc, expire, both_hi, both_lo, done;
  logic unused_strobes;
  assign unused_strobes = ^{di_read, di_write};
  always_comb begin
    match_idx = '0;
    match_vld = 1'b0;
    for (int i = NUM_TERMS - 1; i >= 0; i--)
      if (TERM_ADDRS[i*16 +: 16] == di_term_addr) begin
        match_idx = IW'(i);
        match_vld = 1'b1;
      end
  end
  assign both_hi = di_read_mode && di_write_mode;
  assign both_lo = !di_read_mode && !di_write_mode;
  assign rdy_rel = lat_rd ? term_read_rdy[lat_idx] : term_write_rdy[lat_idx];
  assign wd_inc  = state == ST_ACTIVE && lat_vld && !rdy_rel;
  di_term_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wd (
    .ifclk  (ifclk),
    .resetb (resetb),
    .inc    (wd_inc),
    .clr    (!wd_inc),
    .expire (expire)
  );
  // The latched mode dropping ends the transaction, even if the other mode rises on the same cycle.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   state_nx = both_hi ? ST_PROTO : (di_read_mode || di_write_mode) ? ST_ACTIVE : ST_IDLE;
      ST_ACTIVE: state_nx = both_hi ? ST_PROTO : !(lat_rd ? di_read_mode : di_write_mode) ? ST_IDLE :
                            expire ? ST_TIMEOUT : ST_ACTIVE;
      default:   state_nx = both_lo ? ST_IDLE : state;
    endcase
  end
  assign done = state != ST_IDLE && state_nx == ST_IDLE;
  always_ff @(posedge ifclk or negedge resetb)
    if (!resetb) begin
      state        <= ST_IDLE;
      lat_idx      <= '0;
      lat_vld      <= 1'b0;
      lat_rd       <= 1'b0;
      txn_count    <= '0;
      err_count    <= '0;
      timeout_flag <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == ST_IDLE && state_nx == ST_ACTIVE) begin
        lat_idx <= match_idx;
        lat_vld <= match_vld;
        lat_rd  <= di_read_mode;
      end
      if (done) txn_count <= txn_count + 1'b1;
      if (done && !(state == ST_ACTIVE && lat_vld) && err_count != 8'hFF) err_count <= err_count + 1'b1;
      if (state == ST_ACTIVE && state_nx == ST_TIMEOUT) timeout_flag <= 1'b1;
    end
  assign sel_idx = state == ST_IDLE ? match_idx : lat_idx;
  assign sel_vld = state == ST_IDLE ? match_vld : state == ST_ACTIVE && lat_vld;
  assign di_reg_datao = sel_vld ? term_reg_datao[sel_idx*32 +: 32] : DEFAULT_DATA;
  assign di_read_rdy  = !sel_vld || term_read_rdy[sel_idx];
  assign di_write_rdy = !sel_vld || term_write_rdy[sel_idx];
  assign di_transfer_status = sel_vld ? term_transfer_status[sel_idx*16 +: 16] :
                              state == ST_TIMEOUT ? ERR_TIMEOUT : state == ST_PROTO ? ERR_PROTO : ERR_UNDEF;
  assign term_sel = sel_vld ? NUM_TERMS'(1) << sel_idx : '0;
endmodule
